// File: rtl/lcd16x2_pkg.sv
// Shared constants for the lcd16x2 message sequencer.
// Holds the driver ops codes, the HD44780 init command bytes, the last
// table index, the sequencer FSM state encoding, and a helper that extracts
// one character from a 16-char packed message parameter.
package lcd16x2_pkg;

  localparam logic [1:0] OPS_CMD  = 2'b00;  // RS=0
  localparam logic [1:0] OPS_CHAR = 2'b01;  // RS=1

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE0    = 8'h80;  // DDRAM 0x00
  localparam logic [7:0] CMD_LINE1    = 8'hC0;  // DDRAM 0x40

  localparam logic [5:0] SEQ_LAST      = 6'd37;
  localparam logic [5:0] SEQ_L0_FIRST  = 6'd5;
  localparam logic [5:0] SEQ_L0_LAST   = 6'd20;
  localparam logic [5:0] SEQ_L1_CMD    = 6'd21;
  localparam logic [5:0] SEQ_L1_FIRST  = 6'd22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_WAIT_DONE
  } seq_state_e;

  // Char 0 sits in the top byte so that a plain string literal reads
  // left-to-right on the display.
  function automatic logic [7:0] msg_char(input logic [127:0] msg, input logic [3:0] k);
    return msg[8*(15-int'(k)) +: 8];
  endfunction

endpackage

// File: rtl/lcd16x2_msg_rom.sv
// Transfer table for one display run.
// Ports:
//   idx_i  [5:0] table index 0..37
//   ops_o  [1:0] OPS_CMD for command entries, OPS_CHAR for characters
//   data_o [7:0] command byte or ASCII character
// Entries 0..4 are the init commands, 5..20 line 0, 21 the line-1 address
// command, 22..37 line 1. Indices past the table read as a zero command.
module lcd16x2_msg_rom
  import lcd16x2_pkg::*;
#(
  parameter logic [127:0] MSG_LINE0 = "Hello World!    ",
  parameter logic [127:0] MSG_LINE1 = "  lcd16x2 demo  "
) (
  input  logic [5:0] idx_i,
  output logic [1:0] ops_o,
  output logic [7:0] data_o
);

  always_comb begin
    ops_o  = OPS_CMD;
    data_o = 8'h00;
    case (idx_i) inside
      6'd0: data_o = CMD_FUNC_SET;
      6'd1: data_o = CMD_DISP_ON;
      6'd2: data_o = CMD_ENTRY;
      6'd3: data_o = CMD_CLEAR;
      6'd4: data_o = CMD_LINE0;
      [SEQ_L0_FIRST:SEQ_L0_LAST]: begin
        ops_o  = OPS_CHAR;
        data_o = msg_char(MSG_LINE0, 4'(idx_i - SEQ_L0_FIRST));
      end
      SEQ_L1_CMD: data_o = CMD_LINE1;
      [SEQ_L1_FIRST:SEQ_LAST]: begin
        ops_o  = OPS_CHAR;
        data_o = msg_char(MSG_LINE1, 4'(idx_i - SEQ_L1_FIRST));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd16x2_msg_seq.sv
// Command/character sequencer feeding the lcd16x2 driver.
// Each run walks the 38-entry transfer table (init commands, line 0,
// line-1 address, line 1) and hands every entry to the driver with a
// rdy/enb handshake.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   start_i  1-cycle pulse starting a run (ignored while busy or on done cycle)
//   rdy_i    driver idle / accepting
//   data_o   command byte or character to driver
//   ops_o    2'b00 command, 2'b01 character write
//   enb_o    transfer request
//   busy_o   run in progress
//   done_o   1-cycle pulse after the last transfer completes
module lcd16x2_msg_seq
  import lcd16x2_pkg::*;
#(
  parameter logic [127:0] MSG_LINE0 = "Hello World!    ",
  parameter logic [127:0] MSG_LINE1 = "  lcd16x2 demo  ",
  parameter logic         AUTOSTART = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rdy_i,
  output logic [7:0] data_o,
  output logic [1:0] ops_o,
  output logic       enb_o,
  output logic       busy_o,
  output logic       done_o
);

  seq_state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ops_q, ops_d;
  logic       enb_q, enb_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  // Armed by reset; consumed by the first run so AUTOSTART fires once per
  // reset release.
  logic       auto_q, auto_d;

  logic [1:0] rom_ops;
  logic [7:0] rom_data;

  lcd16x2_msg_rom #(
    .MSG_LINE0(MSG_LINE0),
    .MSG_LINE1(MSG_LINE1)
  ) u_rom (
    .idx_i (idx_q),
    .ops_o (rom_ops),
    .data_o(rom_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      data_q  <= 8'h00;
      ops_q   <= OPS_CMD;
      enb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= AUTOSTART;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ops_q   <= ops_d;
      enb_q   <= enb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ops_d   = ops_q;
    enb_d   = enb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    auto_d  = auto_q;
    case (state_q)
      ST_IDLE: begin
        // done_q is still high on the first IDLE cycle; a start there is
        // dropped so a run can't be chained onto its own done pulse.
        if (auto_q || (start_i && !done_q)) begin
          idx_d   = 6'd0;
          busy_d  = 1'b1;
          auto_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Only place data/ops change: they stay frozen through the whole
        // handshake of the entry.
        data_d  = rom_data;
        ops_d   = rom_ops;
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (rdy_i) begin
          enb_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // rdy falling is the driver's accept; no timeout by design.
        if (!rdy_i) begin
          enb_d   = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (rdy_i) begin
          if (idx_q == SEQ_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o = data_q;
  assign ops_o  = ops_q;
  assign enb_o  = enb_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_lcd16x2_msg_seq.sv
// Bench for lcd16x2_msg_seq: two instances (AUTOSTART=1 default messages,
// AUTOSTART=0 custom messages), each served by a behavioural driver model
// and watched by a transfer logger / handshake monitor.
module tb_lcd16x2_msg_seq;

  localparam logic [127:0] L0A = "Hello World!    ";
  localparam logic [127:0] L1A = "  lcd16x2 demo  ";
  localparam logic [127:0] L0B = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] L1B = "0123456789abcdef";

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst[2], start[2], rdy[2], enb[2], busy[2], done[2];
  logic [7:0] data[2];
  logic [1:0] ops[2];
  int         fall_dly[2], nrise[2];
  int         tests = 0, fails = 0;

  lcd16x2_msg_seq #(.MSG_LINE0(L0A), .MSG_LINE1(L1A), .AUTOSTART(1'b1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .rdy_i(rdy[0]),
    .data_o(data[0]), .ops_o(ops[0]), .enb_o(enb[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  lcd16x2_msg_seq #(.MSG_LINE0(L0B), .MSG_LINE1(L1B), .AUTOSTART(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .rdy_i(rdy[1]),
    .data_o(data[1]), .ops_o(ops[1]), .enb_o(enb[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  // Driver model: rdy drops fall_dly cycles after enb is seen, rises nrise later.
  int ph[2], cnt[2];
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        rdy[i] <= 1'b1; ph[i] <= 0; cnt[i] <= 0;
      end else case (ph[i])
        0: if (enb[i]) begin
             if (fall_dly[i] <= 1) begin rdy[i] <= 1'b0; ph[i] <= 2; end
             else ph[i] <= 1;
             cnt[i] <= 1;
           end
        1: if (cnt[i] + 1 >= fall_dly[i]) begin rdy[i] <= 1'b0; ph[i] <= 2; cnt[i] <= 1; end
           else cnt[i] <= cnt[i] + 1;
        default: if (cnt[i] >= nrise[i]) begin rdy[i] <= 1'b1; ph[i] <= 0; end
                 else cnt[i] <= cnt[i] + 1;
      endcase
    end

  // Monitor: logs each enb rise, checks data/ops hold until rdy falls and
  // rises again, and flags a second enb rise inside one handshake.
  logic [9:0] logq[2][$];
  int         viol[2], done_cnt[2], enb_len[2], enb_max[2];
  logic       enb_prev[2], hold[2], fell[2];
  logic [9:0] held[2];
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      enb_prev[i] <= enb[i];
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      if (enb[i] === 1'b1) begin
        enb_len[i] <= enb_len[i] + 1;
        if (enb_len[i] + 1 > enb_max[i]) enb_max[i] <= enb_len[i] + 1;
      end else enb_len[i] <= 0;
      if (enb[i] === 1'b1 && enb_prev[i] === 1'b0) begin
        logq[i].push_back({ops[i], data[i]});
        if (hold[i] === 1'b1) viol[i] <= viol[i] + 1;
        hold[i] <= 1'b1; fell[i] <= 1'b0; held[i] <= {ops[i], data[i]};
      end else if (busy[i] !== 1'b1) begin
        hold[i] <= 1'b0;
      end else if (hold[i] === 1'b1) begin
        if ({ops[i], data[i]} !== held[i]) viol[i] <= viol[i] + 1;
        if (rdy[i] === 1'b0) fell[i] <= 1'b1;
        else if (fell[i]) hold[i] <= 1'b0;
      end
    end

  // Reference: transfer k of a run, straight from the display recipe.
  function automatic logic [9:0] exp_xfer(input logic [127:0] m0, input logic [127:0] m1, input int k);
    logic [7:0]   hdr[5];
    logic [127:0] t;
    hdr = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    if (k < 5) return {2'b00, hdr[k]};
    if (k < 21) begin t = m0 >> (8 * (20 - k)); return {2'b01, t[7:0]}; end
    if (k == 21) return {2'b00, 8'hC0};
    t = m1 >> (8 * (37 - k));
    return {2'b01, t[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_run(input int i, input int base, input logic [127:0] m0, input logic [127:0] m1);
    chk($sformatf("run_len%0d", i), 32'(logq[i].size() - base), 32'd38);
    for (int k = 0; k < 38 && base + k < logq[i].size(); k++)
      chk($sformatf("xfer%0d_%0d", i, k), 32'(logq[i][base + k]), 32'(exp_xfer(m0, m1, k)));
  endtask

  task automatic wait_done(input int i, input int budget);
    int c;
    c = 0;
    while (done[i] !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    chk($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
  endtask

  task automatic wait_log(input int i, input int target, input int budget);
    int c;
    c = 0;
    while (logq[i].size() < target && c < budget) begin @(negedge clk); c++; end
    chk($sformatf("log_reach%0d", i), 32'(logq[i].size() >= target), 32'd1);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  initial begin
    int b;
    rst = '{1'b1, 1'b1}; start = '{1'b0, 1'b0};
    fall_dly = '{1, 1}; nrise = '{4, 4};
    repeat (4) @(negedge clk);

    chk("rst_data", 32'(data[0]), 32'h00);
    chk("rst_ops", 32'(ops[0]), 32'h0);
    chk("rst_enb", 32'(enb[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_done", 32'(done[0]), 32'h0);
    chk("rst_no_auto_in_reset", 32'(logq[0].size()), 32'd0);

    // Autostart run after reset release.
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("auto_busy", 32'(busy[0]), 32'd1);
    chk("noauto_idle", 32'(busy[1]), 32'd0);
    wait_done(0, 4000);
    @(negedge clk);
    chk("busy_after", 32'(busy[0]), 32'd0);
    check_run(0, 0, L0A, L1A);
    chk("first", 32'(logq[0][0]), 32'h038);
    chk("sixth", 32'(logq[0][5]), 32'h148);
    chk("twentysecond", 32'(logq[0][21]), 32'h0C0);
    chk("done_cnt1", 32'(done_cnt[0]), 32'd1);
    chk("enb_short", 32'(enb_max[0] < 10), 32'd1);

    // Slow accept; also a start landing on the done cycle must be dropped.
    fall_dly[0] = 10; nrise[0] = $urandom_range(2, 8);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    b = logq[0].size();
    pulse_start(0);
    wait_done(0, 20000);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("start_on_done_ignored", 32'(busy[0]), 32'd0);
    check_run(0, b, L0A, L1A);
    chk("enb_held", 32'(enb_max[0] >= 10), 32'd1);
    chk("done_cnt2", 32'(done_cnt[0]), 32'd2);
    fall_dly[0] = 1;

    // start_i mid-run is ignored.
    nrise[0] = $urandom_range(2, 8);
    b = logq[0].size();
    pulse_start(0);
    wait_log(0, b + 13, 3000);
    pulse_start(0);
    wait_done(0, 4000);
    repeat (5) @(negedge clk);
    check_run(0, b, L0A, L1A);
    chk("done_cnt3", 32'(done_cnt[0]), 32'd3);

    // A fresh reset release re-arms AUTOSTART.
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    b = logq[0].size();
    @(negedge clk);
    chk("auto_rearm", 32'(busy[0]), 32'd1);
    wait_done(0, 4000);
    repeat (2) @(negedge clk);
    check_run(0, b, L0A, L1A);
    chk("viol0", 32'(viol[0]), 32'd0);

    // AUTOSTART=0 instance stayed idle for far more than 100 cycles.
    chk("noauto_log", 32'(logq[1].size()), 32'd0);
    chk("noauto_busy", 32'(busy[1]), 32'd0);
    nrise[1] = $urandom_range(2, 8);
    pulse_start(1);
    wait_done(1, 4000);
    repeat (2) @(negedge clk);
    check_run(1, 0, L0B, L1B);
    chk("done_cnt_b", 32'(done_cnt[1]), 32'd1);

    // Reset at idx 20 abandons the run.
    b = logq[1].size();
    pulse_start(1);
    wait_log(1, b + 21, 3000);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("midrst_enb", 32'(enb[1]), 32'd0);
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_data", 32'(data[1]), 32'h00);
    chk("midrst_ops", 32'(ops[1]), 32'h0);
    rst[1] = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_nomore", 32'(logq[1].size() - b), 32'd21);
    chk("midrst_nodone", 32'(done_cnt[1]), 32'd1);
    chk("midrst_idle", 32'(busy[1]), 32'd0);
    chk("viol1", 32'(viol[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
